// File: rtl/insn_decoder_pkg.sv
// Shared definitions for the comproc instruction decoder: ALU function codes,
// A-operand source codes and the decoded control bundle.
package insn_decoder_pkg;

  localparam logic [5:0] ALU_A   = 6'h00;
  localparam logic [5:0] ALU_INC = 6'h01;
  localparam logic [5:0] ALU_B   = 6'h0F;
  localparam logic [5:0] ALU_AND = 6'h10;
  localparam logic [5:0] ALU_ADD = 6'h20;

  localparam logic [1:0] SRC_STK0 = 2'd0;
  localparam logic [1:0] SRC_FP   = 2'd1;
  localparam logic [1:0] SRC_IP   = 2'd2;
  localparam logic [1:0] SRC_CSTK = 2'd3;

  typedef struct packed {
    logic        imm;
    logic        sign;
    logic [15:0] imm_mask;
    logic [1:0]  src_a;
    logic [5:0]  alu_sel;
    logic        wr_stk1;
    logic        pop;
    logic        push;
    logic        load_stk;
    logic        load_fp;
    logic        load_ip;
    logic        ind_jmp;
    logic        cpop;
    logic        cpush;
    logic        byt;
    logic        rd_mem;
    logic        wr_mem;
  } dec_t;

  function automatic dec_t dec_nop();
    dec_t d;
    d          = '0;
    d.imm_mask = 16'h0000;
    d.src_a    = SRC_STK0;
    d.alu_sel  = ALU_A;
    return d;
  endfunction

endpackage

// File: rtl/insn_decoder.sv
// comproc instruction decoder: 16-bit word to datapath controls.
// Define DECODER_OUTREG_EN to register all outputs (async reset to NOP).
module insn_decoder
  import insn_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] insn,
  output logic        imm,
  output logic        sign,
  output logic [15:0] imm_mask,
  output logic [1:0]  src_a,
  output logic [5:0]  alu_sel,
  output logic        wr_stk1,
  output logic        pop,
  output logic        push,
  output logic        load_stk,
  output logic        load_fp,
  output logic        load_ip,
  output logic        ind_jmp,
  output logic        cpop,
  output logic        cpush,
  output logic        byt,
  output logic        rd_mem,
  output logic        wr_mem
);

  dec_t dec_s;
  dec_t dec_out_s;
  logic is_st_s;

  // Decode the instruction word into the control bundle.
  always_comb begin
    dec_s   = dec_nop();
    is_st_s = 1'b0;
    if (insn[15]) begin
      dec_s.imm      = 1'b1;
      dec_s.imm_mask = 16'h7fff;
      dec_s.alu_sel  = ALU_B;
      dec_s.push     = 1'b1;
      dec_s.load_stk = 1'b1;
    end else begin
      case (insn[14:12])
        3'b000: begin
          dec_s.imm      = 1'b1;
          dec_s.sign     = insn[11];
          dec_s.imm_mask = 16'h0ffe;
          dec_s.src_a    = SRC_IP;
          dec_s.alu_sel  = ALU_ADD;
          dec_s.load_ip  = 1'b1;
          dec_s.cpush    = insn[0];
        end
        3'b010, 3'b011, 3'b100: begin
          dec_s.imm  = 1'b1;
          dec_s.sign = insn[9];
          // Base codes 01/10/11 line up with SRC_FP/IP/CSTK.
          if (insn[11:10] == 2'b00) begin
            dec_s.src_a   = SRC_STK0;
            dec_s.alu_sel = ALU_B;
          end else begin
            dec_s.src_a   = insn[11:10];
            dec_s.alu_sel = ALU_ADD;
          end
          if (insn[14:12] == 3'b100) begin
            dec_s.imm_mask = 16'h03fe;
            dec_s.byt      = 1'b0;
            is_st_s        = insn[0];
          end else begin
            dec_s.imm_mask = 16'h03ff;
            dec_s.byt      = 1'b1;
            is_st_s        = insn[12];
          end
          if (is_st_s) begin
            dec_s.wr_mem = 1'b1;
            dec_s.pop    = 1'b1;
          end else begin
            dec_s.rd_mem   = 1'b1;
            dec_s.push     = 1'b1;
            dec_s.load_stk = 1'b1;
          end
        end
        3'b110: begin
          case (insn[11:10])
            2'b00: begin
              dec_s.imm      = 1'b1;
              dec_s.imm_mask = 16'h03ff;
              dec_s.alu_sel  = ALU_B;
              dec_s.load_ip  = 1'b1;
              dec_s.ind_jmp  = 1'b1;
              dec_s.cpush    = 1'b1;
              dec_s.rd_mem   = 1'b1;
            end
            2'b01: begin
              dec_s.imm      = 1'b1;
              dec_s.sign     = insn[9];
              dec_s.imm_mask = 16'h03ff;
              dec_s.src_a    = SRC_FP;
              dec_s.alu_sel  = ALU_ADD;
              dec_s.load_fp  = 1'b1;
            end
            default: dec_s = dec_nop();
          endcase
        end
        3'b111: begin
          if (!insn[11]) begin
            dec_s.load_stk = 1'b1;
            if (insn[7]) begin
              dec_s.alu_sel = ALU_B;
              dec_s.push    = 1'b1;
            end else begin
              dec_s.alu_sel = insn[5:0];
              dec_s.pop     = insn[6];
            end
          end else begin
            case (insn)
              16'h7800: begin
                dec_s.src_a   = SRC_CSTK;
                dec_s.load_ip = 1'b1;
                dec_s.cpop    = 1'b1;
              end
              16'h7808, 16'h7809: begin
                dec_s.load_stk = 1'b1;
                dec_s.rd_mem   = 1'b1;
                dec_s.byt      = insn[0];
              end
              16'h780C, 16'h780D, 16'h780E, 16'h780F: begin
                dec_s.wr_stk1  = 1'b1;
                dec_s.pop      = 1'b1;
                dec_s.load_stk = ~insn[1];
                dec_s.wr_mem   = 1'b1;
                dec_s.byt      = insn[0];
              end
              default: dec_s = dec_nop();
            endcase
          end
        end
        default: dec_s = dec_nop();
      endcase
    end
  end

`ifdef DECODER_OUTREG_EN
  dec_t dec_r;

  // Output register stage; reset forces the NOP bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_r <= dec_nop();
    end else begin
      dec_r <= dec_s;
    end
  end

  assign dec_out_s = dec_r;
`else
  logic unused_s;
  assign unused_s  = &{1'b0, clk, rst_n};
  assign dec_out_s = dec_s;
`endif

  assign imm      = dec_out_s.imm;
  assign sign     = dec_out_s.sign;
  assign imm_mask = dec_out_s.imm_mask;
  assign src_a    = dec_out_s.src_a;
  assign alu_sel  = dec_out_s.alu_sel;
  assign wr_stk1  = dec_out_s.wr_stk1;
  assign pop      = dec_out_s.pop;
  assign push     = dec_out_s.push;
  assign load_stk = dec_out_s.load_stk;
  assign load_fp  = dec_out_s.load_fp;
  assign load_ip  = dec_out_s.load_ip;
  assign ind_jmp  = dec_out_s.ind_jmp;
  assign cpop     = dec_out_s.cpop;
  assign cpush    = dec_out_s.cpush;
  assign byt      = dec_out_s.byt;
  assign rd_mem   = dec_out_s.rd_mem;
  assign wr_mem   = dec_out_s.wr_mem;

endmodule

// File: tb/tb_insn_decoder.sv
// Self-checking bench for insn_decoder: directed test-plan words plus random
// words compared against an opcode-table reference model.
module tb_insn_decoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] insn;
  logic        imm, sign, wr_stk1, pop, push, load_stk, load_fp, load_ip;
  logic        ind_jmp, cpop, cpush, byt, rd_mem, wr_mem;
  logic [15:0] imm_mask;
  logic [1:0]  src_a;
  logic [5:0]  alu_sel;

  int checks = 0;
  int errors = 0;

  insn_decoder dut (
    .clk(clk), .rst_n(rst_n), .insn(insn),
    .imm(imm), .sign(sign), .imm_mask(imm_mask), .src_a(src_a),
    .alu_sel(alu_sel), .wr_stk1(wr_stk1), .pop(pop), .push(push),
    .load_stk(load_stk), .load_fp(load_fp), .load_ip(load_ip),
    .ind_jmp(ind_jmp), .cpop(cpop), .cpush(cpush), .byt(byt),
    .rd_mem(rd_mem), .wr_mem(wr_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [37:0] observed();
    return {imm, sign, imm_mask, src_a, alu_sel, wr_stk1, pop, push, load_stk,
            load_fp, load_ip, ind_jmp, cpop, cpush, byt, rd_mem, wr_mem};
  endfunction

  // Reference: one rule per documented opcode row, using integer arithmetic.
  function automatic logic [37:0] model(input logic [15:0] w);
    logic        i_imm = 1'b0, i_sign = 1'b0;
    logic [15:0] i_mask = 16'h0000;
    logic [1:0]  i_src = 2'd0;
    logic [5:0]  i_alu = 6'h00;
    logic        i_wstk1 = 1'b0, i_pop = 1'b0, i_push = 1'b0, i_lstk = 1'b0;
    logic        i_lfp = 1'b0, i_lip = 1'b0, i_ij = 1'b0, i_cpop = 1'b0;
    logic        i_cpush = 1'b0, i_byt = 1'b0, i_rd = 1'b0, i_wr = 1'b0;
    int op, base, v;
    v    = int'(w);
    op   = v / 4096;
    base = (v / 1024) % 4;
    if (op >= 8) begin
      i_imm = 1'b1; i_mask = 16'h7fff; i_alu = 6'h0F; i_push = 1'b1; i_lstk = 1'b1;
    end else if (op == 0) begin
      i_imm = 1'b1; i_mask = 16'h0ffe; i_sign = w[11]; i_src = 2'd2;
      i_alu = 6'h20; i_lip = 1'b1; i_cpush = (v % 2 == 1);
    end else if (op == 2 || op == 3 || op == 4) begin
      i_imm  = 1'b1;
      i_sign = w[9];
      i_src  = 2'(base);
      i_alu  = (base == 0) ? 6'h0F : 6'h20;
      i_mask = (op == 4) ? 16'h03fe : 16'h03ff;
      i_byt  = (op != 4);
      if (op == 3 || (op == 4 && v % 2 == 1)) begin
        i_wr = 1'b1; i_pop = 1'b1;
      end else begin
        i_rd = 1'b1; i_push = 1'b1; i_lstk = 1'b1;
      end
    end else if (op == 6 && base == 0) begin
      i_imm = 1'b1; i_mask = 16'h03ff; i_alu = 6'h0F; i_lip = 1'b1;
      i_ij = 1'b1; i_cpush = 1'b1; i_rd = 1'b1;
    end else if (op == 6 && base == 1) begin
      i_imm = 1'b1; i_sign = w[9]; i_mask = 16'h03ff; i_src = 2'd1;
      i_alu = 6'h20; i_lfp = 1'b1;
    end else if (op == 7 && base < 2) begin
      i_lstk = 1'b1;
      if ((v / 128) % 2 == 1) begin
        i_alu = 6'h0F; i_push = 1'b1;
      end else begin
        i_alu = 6'(v % 64); i_pop = ((v / 64) % 2 == 1);
      end
    end else if (v == 'h7800) begin
      i_src = 2'd3; i_lip = 1'b1; i_cpop = 1'b1;
    end else if (v == 'h7808 || v == 'h7809) begin
      i_lstk = 1'b1; i_rd = 1'b1; i_byt = (v % 2 == 1);
    end else if (v >= 'h780C && v <= 'h780F) begin
      i_wstk1 = 1'b1; i_pop = 1'b1; i_wr = 1'b1; i_lstk = (v < 'h780E);
      i_byt = (v % 2 == 1);
    end
    return {i_imm, i_sign, i_mask, i_src, i_alu, i_wstk1, i_pop, i_push, i_lstk,
            i_lfp, i_lip, i_ij, i_cpop, i_cpush, i_byt, i_rd, i_wr};
  endfunction

  task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [15:0] w);
    @(negedge clk);
    insn = w;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_check(input logic [15:0] w);
    apply(w);
    check($sformatf("insn_%h", w), observed(), model(w));
  endtask

  logic [15:0] plan [20] = '{
    16'h8BEF, 16'h0020, 16'h0FF1, 16'h2BCE, 16'h3439, 16'h4C20, 16'h4439,
    16'h4039, 16'h6004, 16'h6420, 16'h7001, 16'h7050, 16'h708F, 16'h7800,
    16'h7808, 16'h780C, 16'h780E, 16'h1234, 16'h5ABC, 16'h780A
  };
  logic [3:0]  tops [8] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h7, 4'h8};

  initial begin
    logic [15:0] w;
    rst_n = 1'b0;
    insn  = 16'h1000;
    #3;
    check("reset_nop", observed(), model(16'h1000));
    check("reset_const", {22'd0, imm_mask}, 38'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) apply_check(plan[i]);

    // Hand-derived spot values from the test plan.
    apply(16'h8BEF);
    check("push_mask", {22'd0, imm_mask}, {22'd0, 16'h7fff});
    apply(16'h0FF1);
    check("call_sign_cpush", {36'd0, sign, cpush}, {36'd0, 2'b11});
    apply(16'h4C20);
    check("ld_cstk", {20'd0, imm_mask, src_a}, {20'd0, 16'h03fe, 2'd3});
    apply(16'h7050);
    check("alu_and_pop", {31'd0, alu_sel, pop}, {31'd0, 6'h10, 1'b1});
    apply(16'h780E);
    check("std_nolstk", {35'd0, load_stk, wr_mem, wr_stk1}, {35'd0, 3'b011});
    apply(16'h6004);
    check("int_flags", {34'd0, load_ip, ind_jmp, cpush, rd_mem}, {34'd0, 4'hF});

    for (int i = 0; i < 300; i++) begin
      w = 16'($urandom);
      apply_check(w);
    end
    for (int i = 0; i < 300; i++) begin
      w = 16'($urandom);
      w[15:12] = tops[$urandom_range(7, 0)];
      apply_check(w);
    end
    for (int i = 0; i < 40; i++) begin
      w = {12'h780, 4'($urandom)};
      apply_check(w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/insn_decoder.md
# insn_decoder

Purely combinational instruction decoder for the comproc stack CPU: maps one 16-bit instruction word to datapath control signals. Those signals cover immediate formation, ALU operand/function select, data-stack and call-stack control, IP/FP load, and memory access. It sits between instruction fetch and the execute datapath. An optional output register is available under a macro.

## Interface
- No parameters.
- clk  in  1  clock; used only with DECODER_OUTREG_EN.
- rst_n  in  1  asynchronous, active-low reset; used only with DECODER_OUTREG_EN.
- insn  in  16  instruction word.
- imm  out  1  B operand is the immediate.
- sign  out  1  sign-extend the immediate from the MSB of imm_mask.
- imm_mask  out  16  field mask applied to insn to form the immediate.
- src_a  out  2  A source: 0 = stk0, 1 = fp, 2 = ip, 3 = cstk.
- alu_sel  out  6  ALU function code.
- wr_stk1  out  1  write data comes from stack[1].
- pop, push, load_stk  out  1 each  data-stack pop / push / load top-of-stack.
- load_fp, load_ip  out  1 each  load FP / load IP.
- ind_jmp  out  1  IP is loaded from memory; this is an indirect/vector jump.
- cpop, cpush  out  1 each  call-stack pop / push.
- byt  out  1  memory access is byte-sized.
- rd_mem, wr_mem  out  1 each  memory read / write.

## Operation
Defaults for every output not listed under an opcode: 0, with imm_mask = 0x0000, src_a = stk0 and alu_sel = ALU_A.
- insn[15] = 1, push uimm15: imm = 1, sign = 0, mask = 0x7fff, ALU_B, push = 1, load_stk = 1.
- insn[15:12] = 0000, jmp/call ip+simm12: imm = 1, mask = 0x0ffe, sign = insn[11], src_a = ip, ALU_ADD, load_ip = 1. Call is insn[0] = 1, which also sets cpush = 1.
- Load/store forms with a 10-bit offset: imm = 1, sign = insn[9]. Base is insn[11:10]: 00 gives absolute addressing with ALU_B; 01/10/11 give fp/ip/cstk with ALU_ADD.
  - 0010 ld.1: mask = 0x03ff, byt = 1, rd_mem = 1, push = 1, load_stk = 1.
  - 0011 st.1: mask = 0x03ff, byt = 1, wr_mem = 1, pop = 1.
  - 0100 ld (insn[0] = 0) / st (insn[0] = 1): mask = 0x03fe, byt = 0. ld and st otherwise behave as ld.1 and st.1.
- 0110, insn[11:10] = 00, int uimm10: imm = 1, sign = 0, mask = 0x03ff, ALU_B, load_ip = 1, ind_jmp = 1, cpush = 1, rd_mem = 1.
- 0110, insn[11:10] = 01, add fp,simm10: imm = 1, sign = insn[9], mask = 0x03ff, src_a = fp, ALU_ADD, load_fp = 1.
- 0111, insn[11] = 0, stack ALU/dup:
  - insn[7] = 0: src_a = stk0, alu_sel = insn[5:0], pop = insn[6], load_stk = 1.
  - insn[7] = 1 (dup n): ALU_B, push = 1, load_stk = 1. The depth field is not decoded here.
- 0111, insn[11] = 1, memory/ret group. byt = insn[0] for codes 0x7808–0x780F.
  - 0x7800 ret: src_a = cstk, ALU_A, load_ip = 1, cpop = 1.
  - 0x7808/9 ldd: src_a = stk0, ALU_A, load_stk = 1, rd_mem = 1.
  - 0x780C/D sta: src_a = stk0, ALU_A, wr_stk1 = 1, pop = 1, load_stk = 1, wr_mem = 1.
  - 0x780E/F std: as sta, but load_stk = 0.
- All other encodings (0001, 0101, 0110 with base 1x, unlisted 0x78xx codes) decode to defaults, i.e. a NOP.

## Timing
- Default build: zero latency; outputs are a pure function of insn; clk and rst_n are ignored.
- With DECODER_OUTREG_EN: outputs update one cycle after insn, at rising clk.
  - Reset drives every output to its default value asynchronously.
  - Reset asserted mid-stream forces the NOP value immediately.

## Configuration
- DECODER_OUTREG_EN defined: all outputs pass through one register stage clocked by clk and reset by rst_n, with NOP values on reset.
- DECODER_OUTREG_EN undefined: combinational outputs.

## Structure
- The shared package (common) holds the ALU codes and the src_a codes.
  - ALU codes: ALU_A = 6'h00, ALU_INC = 6'h01, ALU_B = 6'h0F, ALU_AND = 6'h10, ALU_ADD = 6'h20.
  - src_a codes: SRC_STK0/FP/IP/CSTK = 0/1/2/3.
- No sub-module; the optional register stage is inline.

## Test plan
- 0x8BEF → imm = 1, sign = 0, mask = 0x7fff, ALU_B, push = 1, load_stk = 1, rd/wr = 0.
- 0x0020 → mask = 0x0ffe, sign = 0, ip, ALU_ADD, load_ip = 1, cpush = 0.
- 0x0FF1 → as 0x0020, but sign = 1 and cpush = 1.
- 0x2BCE / 0x3439 / 0x4C20 / 0x4439 / 0x4039 → ld.1 ip sign = 1 / st.1 fp sign = 0 / ld cstk mask = 0x03fe / st fp / st absolute ALU_B, with push/pop, byt, rd/wr as specified.
- 0x6004 → int: ALU_B, load_ip = 1, ind_jmp = 1, cpush = 1. 0x6420 → fp, ALU_ADD, load_fp = 1.
- Non-immediate opcodes:
  - 0x7001: ALU_INC, load_stk = 1, pop = 0.
  - 0x7050: ALU_AND, pop = 1.
  - 0x708F: push = 1, ALU_B.
  - 0x7800: cstk, cpop = 1, load_ip = 1.
  - 0x7808, 0x780C, 0x780E: per the ldd/sta/std rows, byt = 0.
